pc_sequencer: RTL and testbench

Fetch-side controller that owns the program counter and sequences instruction fetch.
- Issues one outstanding instruction-memory request at a time.
- Buffers the returned word until decode accepts it.
- Applies redirects (branch/jump/trap) from execute, squashing any in-flight fetch.
- Sits between the core's execute stage and the instruction memory port; replaces the free-running PC incrementer.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_seq_next.sv | 44 ++++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
// Contents: FSM state enum, next-pc selector enum, PC step and default parameters.
// Imported by pc_seq_next and pc_sequencer.
package pc_seq_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
   localparam int          PC_STEP      = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      KILL
   } state_t;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_INC,
      PC_REDIR
   } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch interface bundle: imem request/response, decode handoff, execute redirect.
// master = pc_sequencer side, slave = memory/decode/execute side.
// No logic; signals keep the core's io_* names.
interface pc_sequencer_if #(
   parameter int XLEN = 32
);
   logic            io_imem_req_valid;
   logic            io_imem_req_ready;
   logic [XLEN-1:0] io_imem_req_addr;
   logic            io_imem_resp_valid;
   logic [XLEN-1:0] io_imem_resp_data;
   logic            io_inst_valid;
   logic            io_inst_ready;
   logic [XLEN-1:0] io_inst_data;
   logic [XLEN-1:0] io_inst_pc;
   logic            io_redirect_valid;
   logic [XLEN-1:0] io_redirect_pc;
   logic            io_misalign;

   modport master (
      output io_imem_req_valid, io_imem_req_addr, io_inst_valid,
             io_inst_data, io_inst_pc, io_misalign,
      input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
             io_inst_ready, io_redirect_valid, io_redirect_pc
   );

   modport slave (
      input  io_imem_req_valid, io_imem_req_addr, io_inst_valid,
             io_inst_data, io_inst_pc, io_misalign,
      output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
             io_inst_ready, io_redirect_valid, io_redirect_pc
   );
endinterface

// File: rtl/pc_seq_next.sv
// Next-PC selector: hold, pc+4 (wraps modulo 2^XLEN) or redirect target.
// Purely combinational, zero latency, no backpressure.
// PC_SEQ_MISALIGN_TRAP_EN: misaligned redirect goes to TRAP_VEC and raises misalign;
// otherwise the target's low two bits are cleared and misalign stays 0.
module pc_seq_next
   import pc_seq_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
   input  logic [XLEN-1:0] pc,
   input  pc_sel_t         sel,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] next_pc,
   output logic            misalign
);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic target_misaligned;
   assign target_misaligned = (redirect_pc[1:0] != 2'b00);

   always_comb begin
      next_pc  = pc;
      misalign = 1'b0;
      case (sel)
         PC_INC:   next_pc = pc + XLEN'(PC_STEP);
         PC_REDIR: begin
            if (TRAP_EN && target_misaligned) begin
               next_pc  = TRAP_VEC;
               misalign = 1'b1;
            end else begin
               next_pc  = redirect_pc & ~XLEN'(3);
            end
         end
         default:  next_pc = pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: one outstanding imem request, one-entry instruction buffer,
// redirects squash in-flight fetches. Latency: >= 3 cycles + memory latency per inst.
// Backpressure: holds the buffered inst (no new request) until io_inst_ready.
// Ports: clock, reset (async active-low), bus (pc_sequencer_if.master).
// PC_SEQ_MISALIGN_TRAP_EN enables the misaligned-redirect trap (see pc_seq_next).
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
   input  logic           clock,
   input  logic           reset,
   pc_sequencer_if.master bus
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_next;
   logic [XLEN-1:0] inst_data_q;
   pc_sel_t         pc_sel;
   logic            load_buf;
   logic            misalign_flag;
   logic            misalign_q;

   logic redirect, req_hs, resp;
   assign redirect = bus.io_redirect_valid;
   assign req_hs   = (state_q == REQ) && bus.io_imem_req_ready;
   // Responses outside WAIT/KILL are never looked at by the FSM.
   assign resp     = bus.io_imem_resp_valid;

   pc_seq_next #(
      .XLEN     (XLEN),
      .TRAP_VEC (TRAP_VEC)
   ) u_next (
      .pc          (pc_q),
      .sel         (pc_sel),
      .redirect_pc (bus.io_redirect_pc),
      .next_pc     (pc_next),
      .misalign    (misalign_flag)
   );

   // Redirect overrides every other event in every state.
   always_comb begin
      state_d  = state_q;
      pc_sel   = redirect ? PC_REDIR : PC_HOLD;
      load_buf = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (redirect)    state_d = req_hs ? KILL : REQ;
            else if (req_hs) state_d = WAIT;
         end
         WAIT: begin
            if (redirect) begin
               // Response in the redirect cycle is dropped; otherwise it is orphaned.
               state_d = resp ? REQ : KILL;
            end else if (resp) begin
               state_d  = HOLD;
               load_buf = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               state_d = REQ;
            end else if (bus.io_inst_ready) begin
               state_d = REQ;
               pc_sel  = PC_INC;
            end
         end
         KILL: if (resp) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         inst_data_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_next;
         misalign_q <= redirect && misalign_flag;
         if (load_buf) inst_data_q <= bus.io_imem_resp_data;
      end
   end

   assign bus.io_imem_req_valid = (state_q == REQ);
   assign bus.io_imem_req_addr  = pc_q;
   assign bus.io_inst_valid     = (state_q == HOLD);
   assign bus.io_inst_data      = inst_data_q;
   assign bus.io_inst_pc        = pc_q;
   assign bus.io_misalign       = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: flag-based fetch model plus directed scenarios
// and a randomized phase with random memory latency, ready, redirects and stray responses.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] TVEC   = 32'h0000_0100;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;

   pc_sequencer_if #(.XLEN(32)) bus ();

   pc_sequencer #(
      .XLEN     (32),
      .RESET_PC (RST_PC),
      .TRAP_VEC (TVEC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Model: fetch pipeline described by flags, not by state names.
   logic [31:0] m_pc, m_data, m_tgt;
   bit m_started, m_full, m_out, m_orphan, m_mis;
   bit m_req, m_hs, m_rsp, m_redir;

   // Memory environment.
   bit          mem_pend;
   int          mem_lat;
   logic [31:0] mem_data;
   int          fixed_lat  = 2;
   bit          rand_ready = 1'b0;
   int          spur_pct   = 0;
   logic [31:0] req_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
   endfunction

   function automatic logic [31:0] tgt_of(input logic [31:0] t);
      if (TRAP_EN && t[1:0] != 2'b00) return TVEC;
      return {t[31:2], 2'b00};
   endfunction

   // Model + memory bookkeeping on each clock edge / async reset.
   initial forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
         m_pc = RST_PC; m_data = '0;
         m_started = 0; m_full = 0; m_out = 0; m_orphan = 0; m_mis = 0;
         mem_pend = 0;
      end else begin
         m_req   = m_started && !m_full && !m_out;
         m_hs    = m_req && bus.io_imem_req_ready;
         m_rsp   = bus.io_imem_resp_valid;
         m_redir = bus.io_redirect_valid;
         m_tgt   = tgt_of(bus.io_redirect_pc);
         if (bus.io_imem_resp_valid) mem_pend = 0;
         if (bus.io_imem_req_valid && bus.io_imem_req_ready) begin
            mem_pend = 1;
            mem_lat  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            mem_data = mem_word(bus.io_imem_req_addr);
            req_log.push_back(bus.io_imem_req_addr);
         end
         m_mis = TRAP_EN && m_redir && (bus.io_redirect_pc[1:0] != 2'b00);
         if (!m_started) begin
            m_started = 1;
            if (m_redir) m_pc = m_tgt;
         end else if (m_redir) begin
            m_pc   = m_tgt;
            m_full = 0;
            if (m_out) begin
               if (m_rsp) begin m_out = 0; m_orphan = 0; end
               else m_orphan = 1;
            end else if (m_hs) begin
               m_out = 1; m_orphan = 1;
            end
         end else begin
            if (m_full && bus.io_inst_ready) begin
               m_full = 0;
               m_pc   = m_pc + 32'd4;
            end
            if (m_out && m_rsp) begin
               m_out = 0;
               if (!m_orphan) begin m_full = 1; m_data = bus.io_imem_resp_data; end
               m_orphan = 0;
            end else if (m_hs) begin
               m_out = 1; m_orphan = 0;
            end
         end
      end
   end

   // Compare every cycle while out of reset.
   initial forever begin
      @(negedge clock);
      if (reset) begin
         chk("req_valid",  32'(bus.io_imem_req_valid), 32'(m_started && !m_full && !m_out));
         chk("req_addr",   bus.io_imem_req_addr, m_pc);
         chk("inst_valid", 32'(bus.io_inst_valid), 32'(m_full));
         chk("inst_pc",    bus.io_inst_pc, m_pc);
         if (m_full) chk("inst_data", bus.io_inst_data, m_data);
         chk("misalign",   32'(bus.io_misalign), 32'(m_mis));
      end
   end

   task automatic step();
      @(negedge clock);
      if (mem_pend) begin
         if (mem_lat <= 1) begin
            bus.io_imem_resp_valid = 1'b1;
            bus.io_imem_resp_data  = mem_data;
         end else begin
            bus.io_imem_resp_valid = 1'b0;
            mem_lat--;
         end
      end else begin
         bus.io_imem_resp_valid = ($urandom_range(0, 99) < spur_pct);
         bus.io_imem_resp_data  = $urandom;
      end
      bus.io_imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   function automatic bit cond(input int kind, input int n);
      case (kind)
         0:       return m_full;
         1:       return m_out && !m_orphan;
         2:       return req_log.size() > n;
         3:       return m_out && !m_orphan && bus.io_imem_resp_valid;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_until(input int kind, input int n, input string name);
      int i = 0;
      while (!cond(kind, n) && i < 200) begin
         step();
         i++;
      end
      chk(name, 32'(cond(kind, n)), 32'd1);
   endtask

   initial begin
      logic [31:0] hp, hd, t;
      int n, n0, i;
      bit saw;
      bus.io_imem_req_ready  = 1'b1;
      bus.io_imem_resp_valid = 1'b0;
      bus.io_imem_resp_data  = '0;
      bus.io_inst_ready      = 1'b0;
      bus.io_redirect_valid  = 1'b0;
      bus.io_redirect_pc     = '0;

      // Reset state.
      repeat (3) begin
         @(negedge clock);
         chk("rst_req_valid",  32'(bus.io_imem_req_valid), 32'd0);
         chk("rst_req_addr",   bus.io_imem_req_addr, RST_PC);
         chk("rst_inst_valid", 32'(bus.io_inst_valid), 32'd0);
         chk("rst_inst_pc",    bus.io_inst_pc, RST_PC);
         chk("rst_misalign",   32'(bus.io_misalign), 32'd0);
      end
      reset = 1'b1;
      #1 chk("idle_req_valid", 32'(bus.io_imem_req_valid), 32'd0);
      bus.io_inst_ready = 1'b1;
      step();
      chk("first_req_valid", 32'(bus.io_imem_req_valid), 32'd1);
      chk("first_req_addr",  bus.io_imem_req_addr, 32'h0);

      // Sequential fetch, latency 2.
      repeat (14) step();
      chk("seq_count", 32'(req_log.size() >= 3), 32'd1);
      if (req_log.size() >= 3) begin
         chk("seq_addr0", req_log[0], 32'h0);
         chk("seq_addr1", req_log[1], 32'h4);
         chk("seq_addr2", req_log[2], 32'h8);
      end

      // Decode stall for 5 cycles.
      bus.io_inst_ready = 1'b0;
      wait_until(0, 0, "hold_reach");
      hp = m_pc; hd = m_data; n0 = req_log.size();
      chk("hold_data_word", hd, mem_word(hp));
      repeat (5) begin
         step();
         chk("hold_valid", 32'(bus.io_inst_valid), 32'd1);
         chk("hold_pc",    bus.io_inst_pc, hp);
         chk("hold_data",  bus.io_inst_data, hd);
         chk("hold_noreq", 32'(req_log.size()), 32'(n0));
      end
      bus.io_inst_ready = 1'b1;
      n = req_log.size();
      wait_until(2, n, "hold_next_req");
      if (req_log.size() > n) chk("hold_next_addr", req_log[n], hp + 32'd4);

      // Redirect during WAIT, response 3 cycles later is orphaned.
      fixed_lat = 4;
      wait_until(1, 0, "wait_reach");
      bus.io_redirect_valid = 1'b1; bus.io_redirect_pc = 32'h200;
      step();
      bus.io_redirect_valid = 1'b0;
      n = req_log.size(); saw = 0; i = 0;
      while (req_log.size() <= n && i < 200) begin
         step();
         if (bus.io_inst_valid) saw = 1;
         i++;
      end
      chk("kill_timeout", 32'(req_log.size() > n), 32'd1);
      if (req_log.size() > n) chk("kill_next_addr", req_log[n], 32'h200);
      chk("kill_no_inst", 32'(saw), 32'd0);

      // Redirect coincident with response in WAIT.
      fixed_lat = 2;
      wait_until(3, 0, "wait_resp_reach");
      bus.io_redirect_valid = 1'b1; bus.io_redirect_pc = 32'h300;
      step();
      bus.io_redirect_valid = 1'b0;
      chk("coinc_req_valid", 32'(bus.io_imem_req_valid), 32'd1);
      chk("coinc_req_addr",  bus.io_imem_req_addr, 32'h300);

      // Redirect with inst_ready in HOLD.
      bus.io_inst_ready = 1'b0;
      wait_until(0, 0, "hold2_reach");
      bus.io_inst_ready = 1'b1;
      bus.io_redirect_valid = 1'b1; bus.io_redirect_pc = 32'h400;
      step();
      bus.io_redirect_valid = 1'b0;
      chk("hold_redir_valid", 32'(bus.io_imem_req_valid), 32'd1);
      chk("hold_redir_addr",  bus.io_imem_req_addr, 32'h400);

      // Wrap at the top of the address space.
      n = req_log.size();
      bus.io_redirect_valid = 1'b1; bus.io_redirect_pc = 32'hFFFF_FFFC;
      step();
      bus.io_redirect_valid = 1'b0;
      wait_until(2, n + 2, "wrap_reach");
      if (req_log.size() > n + 2) begin
         chk("wrap_squashed", req_log[n],     32'h400);
         chk("wrap_top",      req_log[n + 1], 32'hFFFF_FFFC);
         chk("wrap_zero",     req_log[n + 2], 32'h0);
      end

      // Misaligned redirect target.
      bus.io_redirect_valid = 1'b1; bus.io_redirect_pc = 32'h0000_0102;
      step();
      bus.io_redirect_valid = 1'b0;
      chk("mis_addr",  bus.io_imem_req_addr, 32'h100);
      chk("mis_pulse", 32'(bus.io_misalign), 32'(TRAP_EN));
      step();
      chk("mis_clear", 32'(bus.io_misalign), 32'd0);

      // Randomized traffic.
      rand_ready = 1'b1; fixed_lat = 0; spur_pct = 10;
      for (int k = 0; k < 2000; k++) begin
         step();
         bus.io_inst_ready = 1'($urandom_range(0, 1));
         bus.io_redirect_valid = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       t = $urandom;
            1:       t = 32'hFFFF_FFFC;
            2:       t = 32'h0000_0102;
            default: t = 32'($urandom_range(0, 255)) << 2;
         endcase
         bus.io_redirect_pc = t;
      end
      bus.io_redirect_valid = 1'b0;

      // Asynchronous reset while waiting on memory.
      rand_ready = 1'b0; spur_pct = 0; fixed_lat = 4; bus.io_inst_ready = 1'b1;
      step();
      wait_until(1, 0, "wait2_reach");
      #2 reset = 1'b0;
      #1;
      chk("arst_req_valid",  32'(bus.io_imem_req_valid), 32'd0);
      chk("arst_inst_valid", 32'(bus.io_inst_valid), 32'd0);
      chk("arst_req_addr",   bus.io_imem_req_addr, RST_PC);
      chk("arst_inst_pc",    bus.io_inst_pc, RST_PC);
      step();
      reset = 1'b1;
      #1 chk("arst_idle", 32'(bus.io_imem_req_valid), 32'd0);
      step();
      chk("arst_req_again", 32'(bus.io_imem_req_valid), 32'd1);
      chk("arst_req_addr0", bus.io_imem_req_addr, RST_PC);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
